// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS load/store path: opcodes, FSM states and lane sizes.
package mips_mem_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b011;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD     = 3'd1;
    localparam logic [2:0] ST_RMW_RD = 3'd2;
    localparam logic [2:0] ST_WR     = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam logic [1:0] LANE_BYTE = 2'd0;
    localparam logic [1:0] LANE_HALF = 2'd1;
    localparam logic [1:0] LANE_WORD = 2'd2;
    localparam logic [1:0] LANE_NONE = 2'd3;

    function automatic logic [1:0] op_lane(input logic [2:0] op);
        case (op)
            OP_B, OP_BU: op_lane = LANE_BYTE;
            OP_H, OP_HU: op_lane = LANE_HALF;
            OP_W:        op_lane = LANE_WORD;
            default:     op_lane = LANE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Big-endian byte/half lane handling: extract+extend for loads, insert for sub-word stores.
module mem_lane_merge
    import mips_mem_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] ins_data,
    output logic [31:0] ext_data,
    output logic [31:0] merged
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sign_ext;

    always_comb begin
        // Offset 0 is the most significant lane, so shift = (3 - offset) * 8.
        byte_sh  = {~offset, 3'b000};
        half_sh  = {~offset[1], 4'b0000};
        lane_b   = 8'(word >> byte_sh);
        lane_h   = 16'(word >> half_sh);
        sign_ext = ~op[2];
        ext_data = word;
        merged   = ins_data;
        case (op_lane(op))
            LANE_BYTE: begin
                ext_data = {{24{sign_ext & lane_b[7]}}, lane_b};
                merged   = (word & ~(32'h0000_00ff << byte_sh))
                         | ({24'd0, ins_data[7:0]} << byte_sh);
            end
            LANE_HALF: begin
                ext_data = {{16{sign_ext & lane_h[15]}}, lane_h};
                merged   = (word & ~(32'h0000_ffff << half_sh))
                         | ({16'd0, ins_data[15:0]} << half_sh);
            end
            default: begin
                ext_data = word;
                merged   = ins_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine in front of a word-only data_mem; sub-word stores go through read-modify-write.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_enable,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_store,
    input  logic [2:0]    req_op,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_addr_error,
    output logic [AW-1:0] mem_r_address,
    output logic [AW-1:0] mem_w_address,
    output logic [31:0]   mem_w_data,
    output logic          mem_w_enable,
    input  logic [31:0]   mem_r_data
);

    logic [2:0]    state_q, state_d;
    logic          store_q;
    logic [2:0]    op_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   merge_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [1:0]    req_lane;
    logic          req_err;
    logic [31:0]   lane_word;
    logic [31:0]   lane_ext;
    logic [31:0]   lane_merged;

    // Undefined opcodes are rejected like misaligned accesses rather than guessed at.
    always_comb begin
        req_lane = op_lane(req_op);
        req_err  = ((req_addr >> (AW + 2)) != 32'd0)
                || (req_lane == LANE_NONE)
                || (req_lane == LANE_HALF && req_addr[0])
                || (req_lane == LANE_WORD && req_addr[1:0] != 2'b00)
                || (req_store && req_op[2]);
    end

    // One lane unit serves both paths: RD extracts from memory, WR merges into the captured word.
    assign lane_word = (state_q == ST_WR) ? merge_q : mem_r_data;

    mem_lane_merge u_lane (
        .op       (op_q),
        .offset   (addr_q[1:0]),
        .word     (lane_word),
        .ins_data (wdata_q),
        .ext_data (lane_ext),
        .merged   (lane_merged)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)                      state_d = ST_RESP;
                    else if (!req_store)              state_d = ST_RD;
                    else if (req_lane == LANE_WORD)   state_d = ST_WR;
                    else                              state_d = ST_RMW_RD;
                end
            end
            ST_RD:     state_d = ST_RESP;
            ST_RMW_RD: state_d = ST_WR;
            ST_WR:     state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            store_q <= 1'b0;
            op_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            merge_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (clk_enable) begin
            state_q <= state_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        store_q <= req_store;
                        op_q    <= req_op;
                        addr_q  <= req_addr[AW+1:0];
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        if (req_err) rdata_q <= 32'd0;
                    end
                end
                ST_RD:     rdata_q <= lane_ext;
                ST_RMW_RD: merge_q <= mem_r_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready       = (state_q == ST_IDLE);
        resp_valid      = (state_q == ST_RESP);
        resp_rdata      = rdata_q;
        resp_addr_error = err_q;
        mem_r_address   = addr_q[AW+1:2];
        mem_w_address   = addr_q[AW+1:2];
        mem_w_enable    = (state_q == ST_WR) && store_q;
        mem_w_data      = 32'd0;
        if (mem_w_enable) begin
            mem_w_data = (op_lane(op_q) == LANE_WORD) ? wdata_q : lane_merged;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word-array stand-in for data_mem plus a byte-level reference model.
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    localparam int unsigned AW     = 8;
    localparam int unsigned NWORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_enable = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_store = 1'b0;
    logic [2:0]    req_op = 3'd0;
    logic [31:0]   req_addr = 32'd0;
    logic [31:0]   req_wdata = 32'd0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_addr_error;
    logic [AW-1:0] mem_r_address;
    logic [AW-1:0] mem_w_address;
    logic [31:0]   mem_w_data;
    logic          mem_w_enable;
    logic [31:0]   mem_r_data;

    mem_access_unit #(.AW(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .clk_enable      (clk_enable),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_addr_error (resp_addr_error),
        .mem_r_address   (mem_r_address),
        .mem_w_address   (mem_w_address),
        .mem_w_data      (mem_w_data),
        .mem_w_enable    (mem_w_enable),
        .mem_r_data      (mem_r_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int unsigned i);
        return (i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // data_mem stand-in: combinational read, write gated by the same clk_enable.
    logic [31:0] mem [NWORDS];
    logic        mem_loaded = 1'b0;
    assign mem_r_data = mem[mem_r_address];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < int'(NWORDS); i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (clk_enable && mem_w_enable) begin
            mem[mem_w_address] <= mem_w_data;
        end
    end

    logic en_at_edge = 1'b1;
    always @(posedge clk) en_at_edge <= clk_enable;

    // Expectations for the request in flight (written by main, read by the compare process).
    int          exp_lat, exp_we;
    logic [31:0] exp_waddr, exp_wdata, exp_rdata;
    logic        exp_err;

    int acc_seq = 0, acc_done = 0, done_seq = 0, abort_seq = 0, abort_done = 0;
    int chk_seq = 0, chk_done = 0;
    string       chk_name;
    logic [31:0] chk_got, chk_exp;

    int          n_cmp = 0, n_fail = 0;
    bit          active = 1'b0;
    int          cyc = 0, span = 0;
    logic [31:0] got_wdata = 32'd0, got_waddr = 32'd0, got_rdata = 32'd0, got_lat = 32'd0;
    logic [31:0] got_err = 32'd0;

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Compare process: every negedge, outputs are checked against the in-flight expectation.
    always @(negedge clk) begin
        if (abort_seq != abort_done) begin
            abort_done = abort_seq;
            active = 1'b0;
        end
        if (acc_seq != acc_done) begin
            acc_done = acc_seq;
            active = 1'b1;
            cyc = 0;
            span = 0;
        end
        if (chk_seq != chk_done) begin
            chk_done = chk_seq;
            cmp(chk_name, chk_got, chk_exp);
        end
        if (active) begin
            span++;
            if (en_at_edge) cyc++;
            cmp("w_enable", 32'(mem_w_enable), 32'(cyc == exp_we));
            if (mem_w_enable) begin
                cmp("w_address", 32'(mem_w_address), exp_waddr);
                cmp("w_data", mem_w_data, exp_wdata);
                got_wdata = mem_w_data;
                got_waddr = 32'(mem_w_address);
            end
            cmp("resp_valid", 32'(resp_valid), 32'(cyc == exp_lat));
            cmp("req_ready", 32'(req_ready), 32'(cyc > exp_lat));
            if (resp_valid) begin
                cmp("resp_rdata", resp_rdata, exp_rdata);
                cmp("resp_addr_error", 32'(resp_addr_error), 32'(exp_err));
                got_rdata = resp_rdata;
                got_err   = 32'(resp_addr_error);
                got_lat   = 32'(cyc);
            end
            if (span > 40) begin
                n_cmp++;
                n_fail++;
                $display("FAIL timeout: no completion after %0d cycles", span);
                active = 1'b0;
                done_seq = acc_done;
            end else if (cyc > exp_lat) begin
                active = 1'b0;
                done_seq = acc_done;
            end
        end else begin
            cmp("idle_ready", 32'(req_ready), 32'd1);
            cmp("idle_resp_valid", 32'(resp_valid), 32'd0);
            cmp("idle_w_enable", 32'(mem_w_enable), 32'd0);
        end
    end

    // Reference model state.
    logic [31:0] model_mem [NWORDS];
    logic [31:0] last_rdata = 32'd0;
    bit          pend_write;
    int unsigned pend_idx;
    logic [31:0] pend_word, pend_rdata;

    task automatic issue(input bit st, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd);
        int unsigned nbytes, off, idx, sh;
        logic [31:0] w, v, mask, nw;
        bit err;
        nbytes = (op == OP_W) ? 4 : (op == OP_H || op == OP_HU) ? 2 :
                 (op == OP_B || op == OP_BU) ? 1 : 0;
        err = (addr >= 32'(NWORDS * 4)) || (nbytes == 0) || (st && op[2]);
        if (nbytes != 0 && (addr % nbytes) != 0) err = 1'b1;
        off = addr % 4;
        idx = err ? 0 : addr / 4;
        w = model_mem[idx];
        v = w;
        nw = wd;
        if (nbytes == 1) begin
            v = (w >> (8 * (3 - off))) & 32'hFF;
            if (op == OP_B && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (nbytes == 2) begin
            v = (w >> (16 * (1 - off / 2))) & 32'hFFFF;
            if (op == OP_H && v >= 32768) v = v | 32'hFFFF_0000;
        end
        if (nbytes == 1 || nbytes == 2) begin
            sh = 8 * (4 - nbytes - off);
            mask = ((32'd1 << (8 * nbytes)) - 32'd1) << sh;
            nw = (w & ~mask) | ((wd << sh) & mask);
        end
        exp_err   = err;
        exp_lat   = err ? 1 : (!st ? 2 : (nbytes == 4 ? 2 : 3));
        exp_we    = (err || !st) ? 0 : (nbytes == 4 ? 1 : 2);
        exp_waddr = idx;
        exp_wdata = nw;
        exp_rdata = err ? 32'd0 : (st ? last_rdata : v);
        pend_write = st && !err;
        pend_idx   = idx;
        pend_word  = nw;
        pend_rdata = exp_rdata;

        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = st;
        req_op     = op;
        req_addr   = addr;
        req_wdata  = wd;
        clk_enable = 1'b1;
        @(posedge clk);
        acc_seq++;
        #1;
        // Scramble the request bus so the unit must rely on what it latched.
        req_valid = 1'b0;
        req_store = 1'($urandom);
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic wait_done(input bit stall);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_seq == acc_seq) break;
            if (stall) clk_enable = ($urandom_range(0, 3) != 0);
        end
        clk_enable = 1'b1;
        if (pend_write) model_mem[pend_idx] = pend_word;
        last_rdata = pend_rdata;
    endtask

    task automatic do_req(input bit st, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input bit stall);
        issue(st, op, addr, wd);
        wait_done(stall);
    endtask

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
        chk_name = nm;
        chk_got  = got;
        chk_exp  = exp;
        chk_seq++;
        @(negedge clk);
        #1;
    endtask

    logic [2:0] ops [5];

    initial begin
        ops[0] = OP_B; ops[1] = OP_H; ops[2] = OP_W; ops[3] = OP_BU; ops[4] = OP_HU;
        for (int i = 0; i < int'(NWORDS); i++) model_mem[i] = init_word(i);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        lit("reset_rdata", resp_rdata, 32'd0);

        do_req(1, OP_W, 32'h10, 32'hDEAD_BEEF, 0);
        lit("sw_wdata", got_wdata, 32'hDEAD_BEEF);
        lit("sw_waddr", got_waddr, 32'd4);
        lit("sw_latency", got_lat, 32'd2);
        do_req(0, OP_W, 32'h10, 32'd0, 0);
        lit("lw_rdata", got_rdata, 32'hDEAD_BEEF);

        do_req(1, OP_W, 32'h20, 32'h80FF_7F01, 0);
        do_req(0, OP_B, 32'h20, 32'd0, 0);
        lit("lb_rdata", got_rdata, 32'hFFFF_FF80);
        lit("lb_latency", got_lat, 32'd2);
        do_req(0, OP_BU, 32'h20, 32'd0, 0);
        lit("lbu_rdata", got_rdata, 32'h0000_0080);
        do_req(0, OP_H, 32'h22, 32'd0, 0);
        lit("lh_rdata", got_rdata, 32'h0000_7F01);
        do_req(0, OP_HU, 32'h20, 32'd0, 0);
        lit("lhu_rdata", got_rdata, 32'h0000_80FF);

        do_req(1, OP_W, 32'h20, 32'hAABB_CCDD, 0);
        do_req(1, OP_B, 32'h21, 32'h1234_5678, 0);
        lit("sb_wdata", got_wdata, 32'hAA78_CCDD);
        lit("sb_latency", got_lat, 32'd3);
        do_req(1, OP_H, 32'h22, 32'h0000_1234, 0);
        lit("sh_wdata", got_wdata, 32'hAA78_1234);

        do_req(0, OP_W, 32'h11, 32'd0, 0);
        lit("err_lw_misaligned", got_err, 32'd1);
        lit("err_latency", got_lat, 32'd1);
        lit("err_rdata", got_rdata, 32'd0);
        do_req(0, OP_W, 32'h20, 32'd0, 0);
        do_req(1, OP_H, 32'h23, 32'hFFFF_FFFF, 0);
        lit("err_sh_misaligned", got_err, 32'd1);
        lit("err_sh_rdata", got_rdata, 32'd0);
        do_req(0, OP_W, 32'h400, 32'd0, 0);
        lit("err_lw_range", got_err, 32'd1);
        do_req(1, OP_BU, 32'h20, 32'h5555_5555, 0);
        lit("err_store_op100", got_err, 32'd1);

        // Reset while the SB sits in its read phase: nothing may be written or answered.
        issue(1, OP_B, 32'h25, 32'h0000_00C3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        abort_seq++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_rdata = 32'd0;
        lit("abort_rdata", resp_rdata, 32'd0);
        do_req(0, OP_W, 32'h24, 32'd0, 0);
        lit("abort_mem_intact", got_rdata, init_word(9));

        // Freeze the unit for three cycles while it is driving the write.
        issue(1, OP_H, 32'h30, 32'h0000_BEEF);
        @(negedge clk);
        @(negedge clk);
        clk_enable = 1'b0;
        repeat (3) @(negedge clk);
        clk_enable = 1'b1;
        wait_done(0);
        lit("stall_wr_latency", got_lat, 32'd3);
        do_req(0, OP_HU, 32'h30, 32'd0, 0);
        lit("stall_wr_readback", got_rdata, 32'h0000_BEEF);

        for (int n = 0; n < 300; n++) begin
            int unsigned r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'h400 + $urandom_range(0, 15);
            else             a = $urandom_range(0, 63);
            do_req(1'($urandom_range(0, 1)), ops[$urandom_range(0, 4)], a, $urandom, 1);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
